// File: rtl/exec_muldiv_if.sv
// Handshake and operand bundle between the EX stage and the iterative multiply/divide unit.
interface exec_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, flush_i, op_i, a_i, b_i,
    input  stall_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, flush_i, op_i, a_i, b_i,
    output stall_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// UNROLL bits per cycle, with sign correction on the last iteration and early divide special cases.
module exec_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  exec_muldiv_if.slave  bus
);
  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] res_q, result_q;

  // Operand decode at acceptance
  logic            a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic            neg_d;

  always_comb begin
    is_div   = bus.op_i[2];
    a_signed = (bus.op_i == 3'd1) || (bus.op_i == 3'd2) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    b_signed = (bus.op_i == 3'd1) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    a_neg    = a_signed & bus.a_i[XLEN-1];
    b_neg    = b_signed & bus.b_i[XLEN-1];
    a_mag    = a_neg ? -bus.a_i : bus.a_i;
    b_mag    = b_neg ? -bus.b_i : bus.b_i;
    // Remainder takes the dividend's sign; everything else the XOR of operand signs
    neg_d    = (bus.op_i == 3'd6) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (bus.b_i == '0);
    div_ovf  = ((bus.op_i == 3'd4) || (bus.op_i == 3'd6)) &&
               (bus.a_i == MIN_INT) && (bus.b_i == {XLEN{1'b1}});
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = bus.op_i[1] ? bus.a_i : {XLEN{1'b1}};
    else          spec_res = bus.op_i[1] ? '0 : MIN_INT;
  end

  // Iteration datapath: UNROLL steps per cycle on {hi, lo}
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [XLEN:0]     sum, rem;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, div_raw, div_res, final_res;

  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    sum  = '0;
    rem  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (!op_q[2]) begin
        sum = {1'b0, hi_n} + (lo_n[0] ? {1'b0, mcand_q} : '0);
        {hi_n, lo_n} = {sum, lo_n[XLEN-1:1]};
      end else begin
        rem  = {hi_n, lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], 1'b0};
        if (rem >= {1'b0, mcand_q}) begin
          rem     = rem - {1'b0, mcand_q};
          lo_n[0] = 1'b1;
        end
        hi_n = rem[XLEN-1:0];
      end
    end
    prod      = {hi_n, lo_n};
    prod_s    = neg_q ? -prod : prod;
    mul_res   = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_raw   = op_q[1] ? hi_n : lo_n;
    div_res   = neg_q ? -div_raw : div_raw;
    final_res = op_q[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            op_q    <= bus.op_i;
            neg_q   <= neg_d;
            hi_q    <= '0;
            lo_q    <= is_div ? a_mag : b_mag;
            mcand_q <= is_div ? b_mag : a_mag;
            cnt_q   <= '0;
            if (special) begin
              res_q   <= spec_res;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
              res_q   <= final_res;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (!bus.flush_i) result_q <= res_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs: the finishing value is visible during DONE and retained afterwards
  always_comb begin
    bus.stall_o  = !rst_i && !bus.flush_i &&
                   (((state_q == S_IDLE) && bus.start_i) || (state_q == S_CALC));
    bus.busy_o   = (state_q != S_IDLE);
    bus.valid_o  = (state_q == S_DONE) && !bus.flush_i && !rst_i;
    bus.result_o = bus.valid_o ? res_q : result_q;
  end
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Bench for exec_muldiv_unit: directed cases, special cases, flush, reset and random ops
// checked against an arithmetic reference, on an UNROLL=1 and an UNROLL=4 instance.
module tb_exec_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic start1, start4, flush1, flush4;
  logic [2:0]  op;
  logic [31:0] a, b;
  int n_tests = 0;
  int n_fail  = 0;
  int vcnt1   = 0;

  always #5 clk = ~clk;

  exec_muldiv_if #(.XLEN(XLEN)) bus1 ();
  exec_muldiv_if #(.XLEN(XLEN)) bus4 ();

  assign bus1.start_i = start1;
  assign bus1.flush_i = flush1;
  assign bus1.op_i    = op;
  assign bus1.a_i     = a;
  assign bus1.b_i     = b;
  assign bus4.start_i = start4;
  assign bus4.flush_i = flush4;
  assign bus4.op_i    = op;
  assign bus4.a_i     = a;
  assign bus4.b_i     = b;

  exec_muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  exec_muldiv_unit #(.XLEN(XLEN), .UNROLL(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

  always @(posedge clk) if (bus1.valid_o === 1'b1) vcnt1 <= vcnt1 + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    int qx, qy;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    qx = $signed(x);
    qy = $signed(y);
    r  = '0;
    case (f)
      3'd0: begin p = 64'(x) * 64'(y); r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); r = p[63:32]; end
      3'd3: begin p = 64'(x) * 64'(y); r = p[63:32]; end
      3'd4: if (y == 0) r = '1; else if (x == MIN && y == '1) r = MIN; else r = qx / qy;
      3'd5: if (y == 0) r = '1; else r = x / y;
      3'd6: if (y == 0) r = x; else if (x == MIN && y == '1) r = '0; else r = qx % qy;
      default: if (y == 0) r = x; else r = x % y;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && ((y == 0) || ((f == 3'd4 || f == 3'd6) && x == MIN && y == '1));
  endfunction

  // Presents one instruction and holds start until valid; returns just after the DONE edge with start still high.
  task automatic run_op(input int sel, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int stalls);
    logic st, vl;
    logic [31:0] rs;
    op = f; a = x; b = y;
    if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
    lat = -1; stalls = 0; res = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sel == 4) begin st = bus4.stall_o; vl = bus4.valid_o; rs = bus4.result_o; end
      else          begin st = bus1.stall_o; vl = bus1.valid_o; rs = bus1.result_o; end
      if (st === 1'b1) stalls++;
      if (vl === 1'b1) begin
        res = rs; lat = c;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    start1 = 1'b0; start4 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus1.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall1: got %b want 0", bus1.stall_o); end
    n_tests++; if (bus4.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall4: got %b want 0", bus4.stall_o); end
    @(posedge clk); #1;
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    n_tests++; if (bus1.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus1.busy_o); end
    n_tests++; if (bus1.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus1.valid_o); end
    n_tests++; if (bus1.result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus1.result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_directed();
    logic [31:0] r; int lat, st;
    run_op(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st); idle(1);
    n_tests++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_res: got %h want fffffffe", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL mulhu_lat: got %0d want 33", lat); end
    n_tests++; if (st !== 33) begin n_fail++; $display("FAIL mulhu_stall: got %0d want 33", st); end
    run_op(1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st); idle(1);
    n_tests++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_res: got %h want 00000001", r); end
    run_op(1, 3'd1, 32'h8000_0000, 32'h8000_0000, r, lat, st); idle(1);
    n_tests++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_res: got %h want 40000000", r); end
    run_op(1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, r, lat, st); idle(1);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_res: got %h want ffffffff", r); end
  endtask

  task automatic test_div_directed();
    logic [31:0] r; int lat, st;
    for (int s = 1; s <= 4; s += 3) begin
      run_op(s, 3'd4, 32'hFFFF_FFF9, 32'd2, r, lat, st); idle(1);
      n_tests++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_res_u%0d: got %h want fffffffd", s, r); end
      n_tests++; if (lat !== ((s == 1) ? 33 : 9)) begin n_fail++; $display("FAIL div_lat_u%0d: got %0d want %0d", s, lat, (s == 1) ? 33 : 9); end
      run_op(s, 3'd6, 32'hFFFF_FFF9, 32'd2, r, lat, st); idle(1);
      n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_res_u%0d: got %h want ffffffff", s, r); end
      n_tests++; if (lat !== ((s == 1) ? 33 : 9)) begin n_fail++; $display("FAIL rem_lat_u%0d: got %0d want %0d", s, lat, (s == 1) ? 33 : 9); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] xs [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ws [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r; int lat, st;
    for (int i = 0; i < 4; i++) begin
      run_op(1, fs[i], xs[i], ys[i], r, lat, st); idle(1);
      n_tests++; if (r !== ws[i]) begin n_fail++; $display("FAIL special%0d_res: got %h want %h", i, r, ws[i]); end
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL special%0d_lat: got %0d want 1", i, lat); end
      n_tests++; if (st !== 1) begin n_fail++; $display("FAIL special%0d_stall: got %0d want 1", i, st); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat, st, v0;
    run_op(1, 3'd0, 32'd7, 32'd6, r, lat, st); idle(1);
    n_tests++; if (r !== 32'd42) begin n_fail++; $display("FAIL flush_pre: got %h want 0000002a", r); end
    v0 = vcnt1;
    op = 3'd4; a = 32'd100; b = 32'd7; start1 = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    flush1 = 1'b1; start1 = 1'b0;
    @(negedge clk);
    n_tests++; if (bus1.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus1.stall_o); end
    n_tests++; if (bus1.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus1.valid_o); end
    @(posedge clk); #1;
    flush1 = 1'b0;
    @(negedge clk);
    n_tests++; if (bus1.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus1.busy_o); end
    n_tests++; if (bus1.result_o !== 32'd42) begin n_fail++; $display("FAIL flush_result: got %h want 0000002a", bus1.result_o); end
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if (vcnt1 !== v0) begin n_fail++; $display("FAIL flush_novalid: got %0d pulses want 0", vcnt1 - v0); end
    run_op(1, 3'd0, 32'd3, 32'd4, r, lat, st); idle(1);
    n_tests++; if (r !== 32'd12) begin n_fail++; $display("FAIL flush_next_mul: got %h want 0000000c", r); end
  endtask

  task automatic test_rst_mid();
    int v0;
    v0 = vcnt1;
    op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus1.stall_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", bus1.stall_o); end
    @(posedge clk); #1;
    rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    n_tests++; if (bus1.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus1.busy_o); end
    n_tests++; if (bus1.valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus1.valid_o); end
    n_tests++; if (bus1.result_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", bus1.result_o); end
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if (vcnt1 !== v0) begin n_fail++; $display("FAIL rstmid_novalid: got %0d pulses want 0", vcnt1 - v0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, st, v0;
    v0 = vcnt1;
    run_op(1, 3'd4, 32'd1000, 32'd7, r, lat, st);
    n_tests++; if (r !== 32'd142) begin n_fail++; $display("FAIL b2b_div: got %h want 0000008e", r); end
    run_op(1, 3'd6, 32'd1000, 32'd7, r, lat, st);
    n_tests++; if (r !== 32'd6) begin n_fail++; $display("FAIL b2b_rem: got %h want 00000006", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_accept: got latency %0d want 33", lat); end
    idle(3);
    n_tests++; if (vcnt1 !== v0 + 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", vcnt1 - v0); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return MIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] r, x, y, w; logic [2:0] f; int lat, st, s, wl;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      x = pick(); y = pick();
      s = (i % 3 == 2) ? 4 : 1;
      w = ref_model(f, x, y);
      wl = is_special(f, x, y) ? 1 : ((s == 1) ? 33 : 9);
      run_op(s, f, x, y, r, lat, st); idle(1);
      n_tests++; if (r !== w) begin n_fail++; $display("FAIL rand%0d_u%0d op%0d a=%h b=%h: got %h want %h", i, s, f, x, y, r, w); end
      n_tests++; if (lat !== wl) begin n_fail++; $display("FAIL rand%0d_lat_u%0d: got %0d want %0d", i, s, lat, wl); end
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; flush1 = 1'b0; flush4 = 1'b0;
    op = '0; a = '0; b = '0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_special();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
